// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit. The requester drives the master side.
interface muldiv_unit_if #(
  parameter int XLEN = 64,
  parameter int TAGW = 6
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [TAGW-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fixup at the end.
// Architected divide-by-zero / overflow results and illegal ops skip the
// iterations and complete one edge after acceptance.
module muldiv_unit #(
  parameter int XLEN = 64,
  parameter int TAGW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  output logic         busy,
  muldiv_unit_if.slave bus
);
  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  // Architectural state
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   acc_q, acc_d;      // product accumulator / partial remainder
  logic [PW-1:0]   sh_q, sh_d;        // multiplicand shifting left / divisor
  logic [XLEN-1:0] qm_q, qm_d;        // multiplier shifting right / dividend->quotient
  logic [XLEN-1:0] result_q, result_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic            mul_q, mul_d;
  logic            mulh_q, mulh_d;
  logic            remop_q, remop_d;
  logic            w_q, w_d;
  logic            neg_q, neg_d;      // negate product / quotient
  logic            rneg_q, rneg_d;    // negate remainder
  logic            special_q, special_d;

  // Decode of the presented op
  logic            d_w, d_illegal, d_mul, d_mulh, d_rem, d_sa, d_sb;
  logic            d_div0, d_ovf, d_special, a_neg, b_neg;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, special_res;

  // Iteration and fixup datapath
  logic [XLEN:0]   rem_sh, rem_diff;
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, raw_res, fix_res;

  // Decode op class, extend operands, take magnitudes, detect special cases
  always_comb begin
    d_w       = (bus.in_op >= 4'd8) && (bus.in_op <= 4'd12);
    d_illegal = (bus.in_op >= 4'd13) || (d_w && (XLEN == 32));
    d_mul     = (bus.in_op <= 4'd3) || (bus.in_op == 4'd8);
    d_mulh    = (bus.in_op >= 4'd1) && (bus.in_op <= 4'd3);
    d_rem     = bus.in_op inside {4'd6, 4'd7, 4'd11, 4'd12};
    d_sa      = bus.in_op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd8, 4'd9, 4'd11};
    d_sb      = bus.in_op inside {4'd0, 4'd1, 4'd4, 4'd6, 4'd8, 4'd9, 4'd11};
    if (d_w) begin
      a_ext   = d_sa ? sext32(bus.in_rs1[31:0]) : zext32(bus.in_rs1[31:0]);
      b_ext   = d_sb ? sext32(bus.in_rs2[31:0]) : zext32(bus.in_rs2[31:0]);
      min_val = sext32(32'h8000_0000);
    end else begin
      a_ext   = bus.in_rs1;
      b_ext   = bus.in_rs2;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg     = d_sa && a_ext[XLEN-1];
    b_neg     = d_sb && b_ext[XLEN-1];
    a_mag     = a_neg ? -a_ext : a_ext;
    b_mag     = b_neg ? -b_ext : b_ext;
    d_div0    = !d_mul && (b_ext == '0);
    d_ovf     = !d_mul && d_sa && (a_ext == min_val) && (b_ext == '1);
    d_special = d_illegal || d_div0 || d_ovf;
    special_res = '0;
    if (d_illegal) begin
      special_res = '0;
    end else if (d_div0) begin
      // remainder is the dividend; W forms return it sign-extended from bit 31
      special_res = d_rem ? (d_w ? sext32(bus.in_rs1[31:0]) : bus.in_rs1) : '1;
    end else if (d_ovf) begin
      special_res = d_rem ? '0 : a_ext;
    end
  end

  // Restoring-divide trial subtraction and final sign fixup / result select
  always_comb begin
    rem_sh   = {acc_q[XLEN-1:0], qm_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, sh_q[XLEN-1:0]};
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -qm_q : qm_q;
    rem_fix  = rneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    if (mul_q) begin
      raw_res = mulh_q ? prod_fix[PW-1:XLEN] : prod_fix[XLEN-1:0];
    end else begin
      raw_res = remop_q ? rem_fix : quo_fix;
    end
    fix_res = w_q ? sext32(raw_res[31:0]) : raw_res;
  end

  // Next-state logic: accept, iterate, fix up, hold result, flush
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    qm_d      = qm_q;
    result_d  = result_q;
    tag_d     = tag_q;
    mul_d     = mul_q;
    mulh_d    = mulh_q;
    remop_d   = remop_q;
    w_d       = w_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    special_d = special_q;
    unique case (state_q)
      S_IDLE: begin
        // flush in IDLE blocks acceptance of an op presented the same cycle
        if (bus.in_valid && !flush) begin
          state_d   = S_BUSY;
          tag_d     = bus.in_tag;
          mul_d     = d_mul;
          mulh_d    = d_mulh;
          remop_d   = d_rem;
          w_d       = d_w;
          neg_d     = a_neg ^ b_neg;
          rneg_d    = a_neg;
          special_d = d_special;
          acc_d     = '0;
          if (d_special) begin
            // result is known now; one BUSY cycle with count 0 then DONE
            cnt_d    = '0;
            result_d = special_res;
          end else begin
            cnt_d = d_w ? CW'(32) : CW'(XLEN);
            if (d_mul) begin
              sh_d = PW'(a_mag);
              qm_d = b_mag;
            end else begin
              sh_d = PW'(b_mag);
              // left-align a 32-bit dividend so the MSB-first loop sees it first
              qm_d = d_w ? (a_mag << (XLEN - 32)) : a_mag;
            end
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          if (!special_q) result_d = fix_res;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (mul_q) begin
            if (qm_q[0]) acc_d = acc_q + sh_q;
            sh_d = sh_q << 1;
            qm_d = qm_q >> 1;
          end else if (!rem_diff[XLEN]) begin
            acc_d = PW'(rem_diff);
            qm_d  = {qm_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = PW'(rem_sh);
            qm_d  = {qm_q[XLEN-2:0], 1'b0};
          end
        end
      end
      S_DONE: begin
        if (flush || bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; asynchronous reset discards any in-flight op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      qm_q      <= '0;
      result_q  <= '0;
      tag_q     <= '0;
      mul_q     <= 1'b0;
      mulh_q    <= 1'b0;
      remop_q   <= 1'b0;
      w_q       <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      qm_q      <= qm_d;
      result_q  <= result_d;
      tag_q     <= tag_d;
      mul_q     <= mul_d;
      mulh_q    <= mulh_d;
      remop_q   <= remop_d;
      w_q       <= w_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      special_q <= special_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_result = result_q;
  assign bus.out_tag    = tag_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=64): directed vector table, handshake/flush/
// reset sequences, and random ops against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int XLEN = 64;
  localparam int TAGW = 6;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic busy;

  muldiv_unit_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

  muldiv_unit #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .busy (busy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  tag;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%016h expected=0x%016h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: RISC-V M semantics written with plain wide arithmetic
  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0]       p;
    logic [63:0]        p64;
    logic signed [63:0] s1, s2;
    logic signed [31:0] w1, w2, q32;
    logic               ovf64, ovf32;
    logic [63:0]        r;
    s1 = a; s2 = b;
    w1 = a[31:0]; w2 = b[31:0];
    ovf64 = (a == MIN64) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    r = '0;
    case (op)
      4'd0: r = a * b;
      4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      4'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; r = p[127:64]; end
      4'd3: begin p = {64'b0, a} * {64'b0, b}; r = p[127:64]; end
      4'd4: if (b == 0) r = '1; else if (ovf64) r = a; else r = s1 / s2;
      4'd5: if (b == 0) r = '1; else r = a / b;
      4'd6: if (b == 0) r = a; else if (ovf64) r = '0; else r = s1 % s2;
      4'd7: if (b == 0) r = a; else r = a % b;
      4'd8: begin p64 = {32'b0, a[31:0]} * {32'b0, b[31:0]}; r = sx(p64[31:0]); end
      4'd9: begin
        if (b[31:0] == 0) r = '1;
        else if (ovf32) r = sx(a[31:0]);
        else begin q32 = w1 / w2; r = sx(q32); end
      end
      4'd10: if (b[31:0] == 0) r = '1; else r = sx(a[31:0] / b[31:0]);
      4'd11: begin
        if (b[31:0] == 0) r = sx(a[31:0]);
        else if (ovf32) r = '0;
        else begin q32 = w1 % w2; r = sx(q32); end
      end
      4'd12: if (b[31:0] == 0) r = sx(a[31:0]); else r = sx(a[31:0] % b[31:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Edges from acceptance to out_valid: 1 for shortcut cases, else N+1
  function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic is_w, is_div, is_sdiv, bz, ov;
    if (op >= 4'd13) return 1;
    is_w    = (op >= 4'd8);
    is_div  = (op >= 4'd4) && (op != 4'd8);
    is_sdiv = op inside {4'd4, 4'd6, 4'd9, 4'd11};
    bz = is_w ? (b[31:0] == 0) : (b == 0);
    ov = is_w ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
              : ((a == MIN64) && (b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (is_div && (bz || (is_sdiv && ov))) return 1;
    return is_w ? 33 : 65;
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return MIN64;
      3: return {$urandom, 32'h8000_0000};
      4: return 64'($urandom_range(0, 20));
      5: return {$urandom, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic start_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_tag   = tag;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain(input int delay);
    repeat (delay) @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, cnt;
    logic [63:0] res, a, b, exp;
    logic [5:0]  tg;
    logic [3:0]  op;

    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    vecs.push_back('{4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 6'd5, 64'hFFFF_FFFF_FFFF_FFEB, 65});
    vecs.push_back('{4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 64'hFFFF_FFFF_FFFF_FFFE, 65});
    vecs.push_back('{4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd2, 64'h0, 65});
    vecs.push_back('{4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    vecs.push_back('{4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd4, 64'hFFFF_FFFF_FFFF_FFFD, 65});
    vecs.push_back('{4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd6, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    vecs.push_back('{4'd5,  64'd7, 64'd0, 6'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    vecs.push_back('{4'd6,  64'd7, 64'd0, 6'd8, 64'd7, 1});
    vecs.push_back('{4'd4,  MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 6'd9, MIN64, 1});
    vecs.push_back('{4'd9,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd10, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{4'd12, 64'h0000_0000_FFFF_FFFF, 64'h10, 6'd11, 64'hF, 33});
    vecs.push_back('{4'd8,  64'h1_0000, 64'h1_0000, 6'd12, 64'h0, 33});
    vecs.push_back('{4'd14, 64'd5, 64'd6, 6'd13, 64'h0, 1});
    vecs.push_back('{4'd10, 64'hABCD_0000_FFFF_FFFF, 64'd1, 6'd14, 64'hFFFF_FFFF_FFFF_FFFF, 33});
    vecs.push_back('{4'd11, 64'h1234_5678_FFFF_FFF9, 64'd2, 6'd15, 64'hFFFF_FFFF_FFFF_FFFF, 33});
    vecs.push_back('{4'd7,  64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 6'd16, 64'd5, 65});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_result", bus.out_result, 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_done(lat);
      check($sformatf("vec%0d_result", i), bus.out_result, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), 64'(bus.out_tag), 64'(vecs[i].tag));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      drain(0);
    end

    // Backpressure: result and tag held, no accept while DONE
    start_op(4'd0, 64'd3, 64'd5, 6'd9);
    wait_done(lat);
    check("hs_latency", 64'(lat), 64'd65);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hs_hold_result", bus.out_result, 64'd15);
      check("hs_hold_tag", 64'(bus.out_tag), 64'd9);
      check("hs_hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    drain(0);
    check("hs_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("hs_release_out_valid", 64'(bus.out_valid), 64'd0);
    start_op(4'd5, 64'd100, 64'd7, 6'd3);
    check("hs_b2b_busy", 64'(busy), 64'd1);
    wait_done(lat);
    check("hs_b2b_result", bus.out_result, 64'd14);
    check("hs_b2b_latency", 64'(lat), 64'd65);
    drain(0);

    // in_valid while busy is ignored
    start_op(4'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 6'd7);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 4'd0;
    bus.in_rs1   = 64'hDEAD_BEEF;
    bus.in_rs2   = 64'h1234;
    bus.in_tag   = 6'd60;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("ign_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    wait_done(lat);
    check("ign_result", bus.out_result, 64'hFFFF_FFFF_FFFF_FFF2);
    check("ign_tag", 64'(bus.out_tag), 64'd7);
    drain(1);

    // Flush in BUSY around iteration 20
    start_op(4'd3, 64'hFFFF_FFFF_0000_1234, 64'h5555_AAAA_1234_5678, 6'd20);
    repeat (20) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_busy_in_ready", 64'(bus.in_ready), 64'd1);
    cnt = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) cnt++;
    end
    check("flush_busy_no_output", 64'(cnt), 64'd0);

    // Flush in DONE
    start_op(4'd5, 64'd7, 64'd0, 6'd21);
    wait_done(lat);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_done_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_done_in_ready", 64'(bus.in_ready), 64'd1);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 4'd5;
    bus.in_rs1   = 64'd9;
    bus.in_rs2   = 64'd0;
    bus.in_tag   = 6'd22;
    flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("flush_idle_out_valid", 64'(bus.out_valid), 64'd0);

    // Random ops against the reference model
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = rnd_operand();
      b  = rnd_operand();
      tg = 6'($urandom);
      exp = ref_model(op, a, b);
      start_op(op, a, b, tg);
      wait_done(lat);
      check($sformatf("rnd%0d_op%0d_result", i, op), bus.out_result, exp);
      check($sformatf("rnd%0d_tag", i), 64'(bus.out_tag), 64'(tg));
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(ref_lat(op, a, b)));
      drain($urandom_range(0, 3));
    end

    // Asynchronous reset mid-BUSY
    start_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 6'd5);
    wait_done(lat);
    drain(0);
    start_op(4'd0, 64'd5, 64'd5, 6'd33);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_out_result", bus.out_result, 64'd0);
    check("arst_out_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) cnt++;
    end
    check("arst_no_output", 64'(cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus W variants) that sits beside the single-cycle ALU in the execute stage.
- Accepts one operation via a valid/ready handshake and computes it with a radix-2 shift-add / restoring-division datapath over XLEN (or 32 for W ops) iterations.
- Returns the result with its destination-register tag through a second valid/ready handshake.
- Implements the architected divide-by-zero and signed-overflow results.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64. W ops are illegal when XLEN=32 and are treated as NOP-result 0.
- TAGW, 6, width of the destination-register tag carried with each op.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the in-flight op. Branch mispredict.
- in_valid  in  1  op presented.
- in_ready  out  1  unit can accept (state IDLE).
- in_op  in  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW; 13-15 produce result 0.
- in_rs1  in  XLEN  operand a.
- in_rs2  in  XLEN  operand b.
- in_tag  in  TAGW  destination register.
- out_valid  out  1  result held.
- out_ready  in  1  downstream consumes.
- out_result  out  XLEN  result.
- out_tag  out  TAGW  tag of result.
- busy  out  1  state != IDLE. For hazard stall.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; in_ready=1, out_valid=0, out_result=0, out_tag=0, busy=0; internal accumulators cleared.
- Reset mid-operation discards the op with no output.
- States IDLE, BUSY, DONE.
- IDLE: on in_valid&&in_ready, latch op, tag and operands (converted to magnitudes for signed ops, with sign flags), load iteration counter N. N=XLEN for full-width ops, N=32 for W ops (operands truncated to [31:0], sign- or zero-extended per op). Go to BUSY.
- Special cases bypass BUSY and go straight to DONE on the next edge:
  - Divisor==0: DIV/DIVU quotient = all ones; REM/REMU = dividend. W forms use 32-bit values sign-extended to XLEN.
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend, remainder = 0. DIVW/REMW use the 32-bit most-negative value.
  - Illegal op: result 0.
- BUSY, one iteration per cycle:
  - Multiply: shift-add one multiplier bit into a 2N-bit product.
  - Divide: restoring step producing one quotient bit.
  - Counter decrements; at 0, apply sign fixup and go to DONE. Quotient negated if signs differ; remainder takes the dividend's sign; MULH/MULHSU product negated per operand signs.
- Result selection:
  - MUL: low XLEN bits. MULH*: high XLEN bits.
  - W ops: low 32 bits sign-extended to XLEN (DIVUW/REMUW results are also sign-extended from bit 31).
- Latency: accept at edge k; out_valid=1 after edge k+N+1. Special cases: out_valid=1 after edge k+1.
- DONE: out_valid=1, result and tag stable. On out_ready go to IDLE; in_ready is asserted in that next cycle (no same-cycle accept-while-draining).
- Backpressure: out_result/out_tag hold indefinitely while out_ready=0.
- flush: has priority over every transition. In BUSY or DONE, go to IDLE next edge, out_valid=0, no result emitted. Ignored in IDLE (an op presented that cycle is not accepted).
- in_valid while not in_ready is ignored; operands are not sampled.

Test Plan:
- MUL 7*(-3), XLEN=64, tag 5 → after 65 cycles: out_valid, result 0xFFFFFFFFFFFFFFEB, tag 5.
- MULHU 0xFFFFFFFFFFFFFFFF*0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE; MULH (-1)*(-1) → 0; MULHSU (-1)*2 → 0xFFFFFFFFFFFFFFFF.
- DIV -7/2 → -3, REM -7/2 → -1, DIVU 7/0 → all ones, REM 7/0 → 7, DIV 0x8000000000000000/(-1) → 0x8000000000000000. Each special case has out_valid at cycle 2.
- DIVW 0x00000000_80000000/-1 → 0xFFFFFFFF80000000 in 2 cycles; REMUW 0xFFFFFFFF/0x10 → 0xF after 33 cycles; MULW 0x10000*0x10000 → 0.
- Handshake: hold out_ready=0 for 10 cycles after DONE → result/tag stable and in_ready=0. Release → in_ready=1 the next cycle, and a back-to-back op is accepted.
- Abort: flush at BUSY iteration 20 → no out_valid, in_ready=1 next cycle. Reset low mid-BUSY → all outputs 0 immediately, asynchronously.
